// File: rtl/dsp_fetch_seq_pkg.sv
// dsp_pkg: shared types and constants for the playback fetch sequencer.
package dsp_pkg;

  localparam int ADDR_W    = 20;
  localparam int MAX_SPEED = 8;
  localparam int SPEED_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FETCH,
    ST_EMIT,
    ST_PAUSED
  } state_t;

  // Zero or out-of-range speed factors fall back to normal rate.
  function automatic logic [SPEED_W-1:0] legal_speed(input logic [SPEED_W-1:0] s,
                                                     input int max_speed);
    if (s == '0 || int'(s) > max_speed) return SPEED_W'(1);
    return s;
  endfunction

endpackage

// File: rtl/dsp_fetch_seq_if.sv
// Sample bus between the fetch sequencer, the SRAM read port and the
// interpolator: read address/data plus the per-frame slot strobe.
interface dsp_fetch_seq_if #(
  parameter int ADDR_W = 20
) ();
  logic [ADDR_W-1:0] o_sram_addr;
  logic [15:0]       i_sram_data;
  logic              o_tick;
  logic              o_valid;
  logic [15:0]       o_data;

  modport master (
    output o_sram_addr,
    input  i_sram_data,
    output o_tick,
    output o_valid,
    output o_data
  );

  modport slave (
    input  o_sram_addr,
    output i_sram_data,
    input  o_tick,
    input  o_valid,
    input  o_data
  );
endinterface

// File: rtl/dsp_fetch_seq_lrck_tick.sv
// lrck_tick: brings the DAC LR clock into the i_clk domain and emits a
// one-cycle pulse on each of its rising edges.
module lrck_tick (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_lrck,
  output logic o_tick
);
  // [0],[1] are the synchroniser; [2] is the previous synchronised value.
  logic [2:0] r_sync;

  // Shift the LR clock through the synchroniser / edge-history chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[1:0], i_lrck};
  end

  assign o_tick = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/dsp_fetch_seq.sv
// dsp_fetch_seq: walks 16-bit samples out of SRAM at normal, fast (skip)
// or slow (hold) rate, one sample slot per DAC LR-clock frame.
// Optional feature macro: DSP_REVERSE_EN adds i_reverse (backward playback).
module dsp_fetch_seq #(
  parameter int ADDR_W    = 20,
  parameter int MAX_SPEED = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_pause,
  input  logic                         i_stop,
  input  logic                         i_fast,
  input  logic [dsp_pkg::SPEED_W-1:0]  i_speed,
  input  logic                         i_daclrck,
  input  logic [ADDR_W-1:0]            i_end_addr,
`ifdef DSP_REVERSE_EN
  input  logic                         i_reverse,
`endif
  output logic                         o_paused,
  output logic                         o_done,
  dsp_fetch_seq_if.master              bus
);
  import dsp_pkg::*;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [SPEED_W-1:0]  r_slot, w_slot_next;
  logic [SPEED_W-1:0]  r_speed, w_speed_next;
  logic                r_fast, w_fast_next;
  logic                r_fetched, w_fetched_next;
  logic [15:0]         r_data, w_data_next;
  logic                r_done, w_done_next;
`ifdef DSP_REVERSE_EN
  logic                r_rev, w_rev_next;
`endif

  logic                w_tick;
  logic [SPEED_W-1:0]  w_speed_in;
  logic                w_fetch_slot;
  logic [ADDR_W:0]     w_step;
  logic [ADDR_W:0]     w_sum;
  logic                w_end;

  lrck_tick u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_lrck  (i_daclrck),
    .o_tick  (w_tick)
  );

  assign w_speed_in   = legal_speed(i_speed, MAX_SPEED);
  assign w_fetch_slot = r_fast || (r_speed == SPEED_W'(1)) || (r_slot == '0);
  assign w_step       = r_fast ? {{(ADDR_W+1-SPEED_W){1'b0}}, r_speed} : (ADDR_W+1)'(1);

  // Next address is one bit wider so overflow / underflow is visible.
`ifdef DSP_REVERSE_EN
  assign w_sum = r_rev ? ({1'b0, r_addr} - w_step) : ({1'b0, r_addr} + w_step);
  assign w_end = r_rev ? w_sum[ADDR_W] : (w_sum > {1'b0, i_end_addr});
`else
  assign w_sum = {1'b0, r_addr} + w_step;
  assign w_end = w_sum > {1'b0, i_end_addr};
`endif

  // Register FSM state and datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_slot    <= '0;
      r_speed   <= '0;
      r_fast    <= 1'b0;
      r_fetched <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
`ifdef DSP_REVERSE_EN
      r_rev     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_slot    <= w_slot_next;
      r_speed   <= w_speed_next;
      r_fast    <= w_fast_next;
      r_fetched <= w_fetched_next;
      r_data    <= w_data_next;
      r_done    <= w_done_next;
`ifdef DSP_REVERSE_EN
      r_rev     <= w_rev_next;
`endif
    end
  end

  // Next-state and datapath updates; i_stop overrides everything.
  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_slot_next    = r_slot;
    w_speed_next   = r_speed;
    w_fast_next    = r_fast;
    w_fetched_next = r_fetched;
    w_data_next    = r_data;
    w_done_next    = 1'b0;
`ifdef DSP_REVERSE_EN
    w_rev_next     = r_rev;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_WAIT;
          w_slot_next  = '0;
          w_fast_next  = i_fast;
          w_speed_next = w_speed_in;
`ifdef DSP_REVERSE_EN
          w_rev_next   = i_reverse;
          w_addr_next  = i_reverse ? i_end_addr : '0;
`endif
        end
      end
      ST_WAIT: begin
        if (i_pause) begin
          w_state_next = ST_PAUSED;
        end else if (w_tick) begin
          if (w_fetch_slot) begin
            // Config is only picked up at group boundaries.
            w_state_next   = ST_FETCH;
            w_fetched_next = 1'b1;
            w_fast_next    = i_fast;
            w_speed_next   = w_speed_in;
            w_slot_next    = (i_fast || w_speed_in == SPEED_W'(1)) ? '0 : SPEED_W'(1);
          end else begin
            w_state_next   = ST_EMIT;
            w_fetched_next = 1'b0;
            w_slot_next    = (r_slot >= r_speed - SPEED_W'(1)) ? '0 : r_slot + SPEED_W'(1);
          end
        end
      end
      ST_FETCH: begin
        w_data_next  = bus.i_sram_data;
        w_state_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (r_fetched && w_end) begin
          w_state_next = ST_IDLE;
          w_addr_next  = '0;
          w_done_next  = 1'b1;
        end else begin
          if (r_fetched) w_addr_next = w_sum[ADDR_W-1:0];
          w_state_next = i_pause ? ST_PAUSED : ST_WAIT;
        end
      end
      ST_PAUSED: begin
        if (i_start && !i_pause) w_state_next = ST_WAIT;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (i_stop) begin
      w_state_next = ST_IDLE;
      w_addr_next  = '0;
      w_slot_next  = '0;
      w_done_next  = 1'b0;
    end
  end

  assign bus.o_sram_addr = r_addr;
  assign bus.o_tick      = (r_state == ST_EMIT) && !i_stop;
  assign bus.o_valid     = (r_state == ST_EMIT) && !i_stop && r_fetched;
  assign bus.o_data      = r_data;
  assign o_paused        = (r_state == ST_PAUSED);
  assign o_done          = r_done;
endmodule

// File: tb/tb_dsp_fetch_seq.sv
// Directed bench for dsp_fetch_seq; SRAM word k holds 0x1000 + k.
module tb_dsp_fetch_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0, fast = 1'b0;
  logic [3:0]  speed = 4'd1;
  logic        lrck = 1'b0;
  logic [19:0] end_addr = 20'd0;
  logic        paused, done;

  int n_cmp = 0;
  int n_err = 0;

  dsp_fetch_seq_if #(.ADDR_W(20)) bus ();
  assign bus.i_sram_data = 16'h1000 + bus.o_sram_addr[15:0];

  dsp_fetch_seq #(.ADDR_W(20), .MAX_SPEED(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_pause    (pause),
    .i_stop     (stop),
    .i_fast     (fast),
    .i_speed    (speed),
    .i_daclrck  (lrck),
    .i_end_addr (end_addr),
`ifdef DSP_REVERSE_EN
    .i_reverse  (1'b0),
`endif
    .o_paused   (paused),
    .o_done     (done),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // Strobe log, sampled on the falling edge.
  int   cyc = 0;
  logic log_valid[$];
  logic [15:0] log_data[$];
  logic [19:0] log_addr[$];
  int   log_cyc[$];
  int   done_n = 0;
  int   done_cyc = 0;
  int   stray = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_tick) begin
      log_valid.push_back(bus.o_valid);
      log_data.push_back(bus.o_data);
      log_addr.push_back(bus.o_sram_addr);
      log_cyc.push_back(cyc);
      $display("strobe cyc=%0d valid=%0b addr=%0d data=%h", cyc, bus.o_valid, bus.o_sram_addr, bus.o_data);
    end
    if (done) begin
      done_n <= done_n + 1;
      done_cyc <= cyc;
      $display("done   cyc=%0d", cyc);
    end
    if ((bus.o_valid && !bus.o_tick) || (bus.o_valid && done)) stray <= stray + 1;
  end

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      @(posedge clk); #1 lrck = 1'b1;
      repeat (20) @(posedge clk);
      #1 lrck = 1'b0;
      repeat (20) @(posedge clk);
    end
  endtask

  task automatic go(input logic f, input logic [3:0] s, input logic [19:0] e);
    fast = f; speed = s; end_addr = e;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk); #1 stop = 1'b1;
    repeat (2) @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.o_sram_addr !== 20'd0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", bus.o_sram_addr); end
    n_cmp++; if ({bus.o_tick, bus.o_valid, paused, done} !== 4'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {bus.o_tick, bus.o_valid, paused, done}); end
    n_cmp++; if (bus.o_data !== 16'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", bus.o_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int lat;
    lat = 0;
    go(1'b0, 4'd1, 20'd100);
    @(posedge clk); #1 lrck = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.o_tick && lat == 0) begin
        lat = i;
        n_cmp++; if ({bus.o_valid, bus.o_data} !== {1'b1, 16'h1000}) begin n_err++; $display("FAIL latency_sample got=%b/%h exp=1/1000", bus.o_valid, bus.o_data); end
      end
    end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL latency got=%0d exp=4", lat); end
    repeat (10) @(posedge clk); #1 lrck = 1'b0;
    repeat (10) @(posedge clk);
    do_stop();
  endtask

  task automatic test_normal();
    int b, d0;
    logic [15:0] exp_d [4];
    exp_d[0] = 16'h1000; exp_d[1] = 16'h1001; exp_d[2] = 16'h1002; exp_d[3] = 16'h1003;
    b = log_valid.size(); d0 = done_n;
    go(1'b0, 4'd1, 20'd3);
    frames(5);
    n_cmp++; if (log_valid.size() - b !== 4) begin n_err++; $display("FAIL normal_count got=%0d exp=4", log_valid.size() - b); end
    if (log_valid.size() - b == 4) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if ({log_valid[b+k], log_data[b+k]} !== {1'b1, exp_d[k]}) begin n_err++; $display("FAIL normal_data[%0d] got=%b/%h exp=1/%h", k, log_valid[b+k], log_data[b+k], exp_d[k]); end
      end
      n_cmp++; if (done_cyc !== log_cyc[b+3] + 1) begin n_err++; $display("FAIL normal_done_time got=%0d exp=%0d", done_cyc, log_cyc[b+3] + 1); end
    end
    n_cmp++; if (done_n - d0 !== 1) begin n_err++; $display("FAIL normal_done got=%0d exp=1", done_n - d0); end
    n_cmp++; if (bus.o_sram_addr !== 20'd0) begin n_err++; $display("FAIL normal_end_addr got=%0d exp=0", bus.o_sram_addr); end
  endtask

  task automatic test_fast();
    int b, d0;
    logic [19:0] exp_a [4];
    exp_a[0] = 20'd0; exp_a[1] = 20'd3; exp_a[2] = 20'd6; exp_a[3] = 20'd9;
    b = log_valid.size(); d0 = done_n;
    go(1'b1, 4'd3, 20'd9);
    frames(5);
    n_cmp++; if (log_valid.size() - b !== 4) begin n_err++; $display("FAIL fast_count got=%0d exp=4", log_valid.size() - b); end
    if (log_valid.size() - b == 4) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if ({log_valid[b+k], log_addr[b+k], log_data[b+k]} !== {1'b1, exp_a[k], 16'h1000 + exp_a[k][15:0]}) begin
          n_err++; $display("FAIL fast_fetch[%0d] got=%b/%0d/%h exp=1/%0d", k, log_valid[b+k], log_addr[b+k], log_data[b+k], exp_a[k]);
        end
      end
    end
    n_cmp++; if (done_n - d0 !== 1) begin n_err++; $display("FAIL fast_done got=%0d exp=1", done_n - d0); end
  endtask

  task automatic test_slow();
    int b;
    logic [7:0] exp_v;
    exp_v = 8'b0001_0001;  // bit k = slot k
    b = log_valid.size();
    go(1'b0, 4'd4, 20'd100);
    frames(8);
    do_stop();
    n_cmp++; if (log_valid.size() - b !== 8) begin n_err++; $display("FAIL slow_count got=%0d exp=8", log_valid.size() - b); end
    if (log_valid.size() - b == 8) begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++; if ({log_valid[b+k], log_data[b+k]} !== {exp_v[k], (k < 4) ? 16'h1000 : 16'h1001}) begin
          n_err++; $display("FAIL slow_slot[%0d] got=%b/%h exp=%b/%h", k, log_valid[b+k], log_data[b+k], exp_v[k], (k < 4) ? 16'h1000 : 16'h1001);
        end
      end
    end
  endtask

  task automatic test_pause();
    int b;
    b = log_valid.size();
    go(1'b0, 4'd4, 20'd100);
    frames(2);
    #1 pause = 1'b1;
    frames(2);
    #1;
    n_cmp++; if (log_valid.size() - b !== 2) begin n_err++; $display("FAIL pause_no_strobe got=%0d exp=2", log_valid.size() - b); end
    n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL pause_flag got=%b exp=1", paused); end
    n_cmp++; if (bus.o_sram_addr !== 20'd1) begin n_err++; $display("FAIL pause_addr_hold got=%0d exp=1", bus.o_sram_addr); end
    pause = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    frames(3);
    #1;
    n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL resume_flag got=%b exp=0", paused); end
    n_cmp++; if (log_valid.size() - b !== 5) begin n_err++; $display("FAIL resume_count got=%0d exp=5", log_valid.size() - b); end
    if (log_valid.size() - b == 5) begin
      n_cmp++; if ({log_valid[b+2], log_valid[b+3]} !== 2'b00) begin n_err++; $display("FAIL resume_hold got=%b exp=00", {log_valid[b+2], log_valid[b+3]}); end
      n_cmp++; if ({log_valid[b+4], log_addr[b+4], log_data[b+4]} !== {1'b1, 20'd1, 16'h1001}) begin
        n_err++; $display("FAIL resume_fetch got=%b/%0d/%h exp=1/1/1001", log_valid[b+4], log_addr[b+4], log_data[b+4]);
      end
    end
    do_stop();
  endtask

  task automatic test_stop();
    int b;
    go(1'b0, 4'd1, 20'd100);
    frames(2);
    b = log_valid.size();
    @(posedge clk); #1 lrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 stop = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (log_valid.size() - b !== 0) begin n_err++; $display("FAIL stop_strobe got=%0d exp=0", log_valid.size() - b); end
    n_cmp++; if (bus.o_sram_addr !== 20'd0) begin n_err++; $display("FAIL stop_addr got=%0d exp=0", bus.o_sram_addr); end
    stop = 1'b0;
    repeat (20) @(posedge clk); #1 lrck = 1'b0;
    repeat (10) @(posedge clk);
    b = log_valid.size();
    go(1'b0, 4'd1, 20'd100);
    frames(1);
    n_cmp++; if (log_valid.size() - b !== 1) begin n_err++; $display("FAIL replay_count got=%0d exp=1", log_valid.size() - b); end
    else begin
      n_cmp++; if ({log_valid[b], log_addr[b], log_data[b]} !== {1'b1, 20'd0, 16'h1000}) begin
        n_err++; $display("FAIL replay_fetch got=%b/%0d/%h exp=1/0/1000", log_valid[b], log_addr[b], log_data[b]);
      end
    end
    do_stop();
  endtask

  task automatic test_illegal_speed(input logic [3:0] s);
    int b, d0;
    b = log_valid.size(); d0 = done_n;
    go(1'b0, s, 20'd2);
    frames(4);
    n_cmp++; if (log_valid.size() - b !== 3) begin n_err++; $display("FAIL speed%0d_count got=%0d exp=3", s, log_valid.size() - b); end
    else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++; if ({log_valid[b+k], log_addr[b+k]} !== {1'b1, 20'(k)}) begin
          n_err++; $display("FAIL speed%0d_fetch[%0d] got=%b/%0d exp=1/%0d", s, k, log_valid[b+k], log_addr[b+k], k);
        end
      end
    end
    n_cmp++; if (done_n - d0 !== 1) begin n_err++; $display("FAIL speed%0d_done got=%0d exp=1", s, done_n - d0); end
  endtask

  task automatic test_reset_mid();
    int b;
    go(1'b0, 4'd1, 20'd100);
    frames(1);
    @(posedge clk); #1 lrck = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_sram_addr !== 20'd0) begin n_err++; $display("FAIL rstmid_addr got=%0d exp=0", bus.o_sram_addr); end
    n_cmp++; if (bus.o_data !== 16'h0) begin n_err++; $display("FAIL rstmid_data got=%h exp=0", bus.o_data); end
    n_cmp++; if ({bus.o_tick, bus.o_valid, paused, done} !== 4'b0) begin n_err++; $display("FAIL rstmid_flags got=%b exp=0000", {bus.o_tick, bus.o_valid, paused, done}); end
    @(posedge clk); #1 rst_n = 1'b1;
    b = log_valid.size();
    repeat (15) @(posedge clk); #1 lrck = 1'b0;
    repeat (5) @(posedge clk);
    n_cmp++; if (log_valid.size() - b !== 0) begin n_err++; $display("FAIL rstmid_no_tick got=%0d exp=0", log_valid.size() - b); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_normal();
    test_fast();
    test_slow();
    test_pause();
    test_stop();
    test_illegal_speed(4'd0);
    test_illegal_speed(4'd12);
    test_reset_mid();
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL valid_without_tick got=%0d exp=0", stray); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dsp_fetch_seq.md
# dsp_fetch_seq

Playback sequencer upstream of the slow-speed interpolator. It walks 16-bit audio samples out of the external SRAM at normal, fast (sample-skipping) or slow (sample-holding) rates, paced by the DAC left/right clock. It emits one sample-slot strobe per audio frame. Each strobe either carries a freshly fetched sample with a valid flag, or marks a slot the interpolator must fill itself.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- MAX_SPEED, 8, largest legal speed factor

Ports:
- i_clk  in  1  system clock (all logic on rising edge)
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  level; start playback from IDLE, resume from PAUSED
- i_pause  in  1  level; freeze playback
- i_stop  in  1  level; abort to IDLE, highest priority
- i_fast  in  1  1 = fast (skip), 0 = slow (hold)
- i_speed  in  4  speed factor, 1..MAX_SPEED
- i_daclrck  in  1  DAC LR clock, asynchronous to i_clk
- i_end_addr  in  ADDR_W  last recorded address, inclusive
- i_sram_data  in  16  SRAM read data (asynchronous read)
- o_sram_addr  out  ADDR_W  SRAM read address
- o_tick  out  1  one-cycle strobe per sample slot
- o_valid  out  1  new sample on o_data; only asserted with o_tick
- o_data  out  16  last fetched sample; held between fetches
- o_paused  out  1  high in PAUSED; drives the interpolator's pause input
- o_done  out  1  one-cycle pulse at end of recording

## Operation
- Reset value of all outputs is 0. State resets to IDLE. Internal slot counter and latched config are 0.
- The tick sub-block synchronises i_daclrck with 2 flops and then detects its rising edge. It produces one internal `tick` per frame.
- States: IDLE, WAIT, FETCH, EMIT, PAUSED.
- IDLE:
  - o_sram_addr = 0.
  - i_start goes to WAIT.
  - Entering WAIT clears the slot counter and latches i_fast/i_speed.
- WAIT:
  - i_pause goes to PAUSED.
  - Otherwise, on `tick`: a fetch slot goes to FETCH; any other slot goes to EMIT with no fetch.
- Fetch slot:
  - Fast mode, or speed 1: every tick is a fetch slot.
  - Slow mode: a fetch slot is a tick with slot counter == 0. The slot counter increments per tick and wraps at speed−1.
- FETCH:
  - Lasts one cycle.
  - i_sram_data is registered into o_data at the end of this cycle.
- EMIT:
  - Lasts one cycle.
  - o_tick = 1 in every EMIT cycle.
  - o_valid = 1 if the slot fetched.
  - After a fetch, the address advances by step. Step = speed in fast mode, else 1.
  - i_fast/i_speed are relatched only on fetch slots, so a slow run finishes its current hold group.
- End of recording:
  - Next address = 21-bit sum. If the sum is > i_end_addr, pulse o_done in the following cycle, go to IDLE and reset the address to 0.
- Illegal speed: i_speed of 0 or > MAX_SPEED is treated as 1.
- PAUSED:
  - No strobes are issued. Address, slot counter and o_data are held.
  - When i_start = 1 and i_pause = 0, go to WAIT with the counter preserved.
- Pause asserted during FETCH or EMIT: the slot completes first, then the block enters PAUSED.
- i_stop: from any state, go to IDLE on the next edge. This clears address and counter; o_valid/o_tick are 0 that cycle. i_stop overrides i_start and i_pause.
- A tick arriving outside WAIT is dropped. This cannot happen in normal operation, because the frame period is much longer than 2 cycles.

## Timing
- o_tick/o_valid are asserted 4 i_clk cycles after the i_daclrck rising edge: sync 2, edge 1, FETCH/skip 1.
- o_data updates on the same edge that raises o_valid, and holds until the next fetch.
- o_sram_addr is stable throughout FETCH. The SRAM has a 1-cycle read budget.
- o_done comes one cycle after the final EMIT. o_valid is not asserted alongside o_done.
- Reset mid-operation: asynchronous clear of everything. The first o_tick after release needs a fresh LR-clock rising edge.

## Configuration
- DSP_REVERSE_EN defined:
  - Adds input i_reverse, 1 bit, latched at i_start.
  - When i_reverse = 1, playback starts at i_end_addr and steps downward.
  - End of recording is an address underflow below 0, which is signalled with o_done.
- DSP_REVERSE_EN undefined: the port is absent and playback is forward only.

## Structure
- Package dsp_pkg: state enum, ADDR_W, MAX_SPEED, SPEED_W = 4.
- Sub-module lrck_tick: 2-flop synchroniser plus rising-edge detector, output `tick`.

## Test plan
- Normal run, speed 1, i_end_addr = 3, SRAM[k] = 0x1000+k:
  - 4 o_valid strobes with 0x1000..0x1003.
  - Then o_done, then o_sram_addr = 0.
- Fast mode, speed 3, i_end_addr = 9: fetches addresses 0, 3, 6, 9, then o_done after the 4th strobe.
- Slow mode, speed 4: per 4 frames, o_tick ×4 with o_valid only on the 1st. o_data is constant across the group.
- Pause and resume:
  - Assert i_pause mid-group at slot 2 of 4. No strobes while paused; o_paused = 1.
  - On resume, slots 3 and 4 are non-valid, then the next fetch is at address +1.
- i_stop coincident with a fetch slot: o_valid stays 0, state goes to IDLE, address 0. A subsequent i_start replays from address 0.
- i_speed = 0 and i_speed = 12 both behave as speed 1. Asserting i_rst_n low mid-FETCH clears all outputs immediately.
